// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - Requester and transmitter-side signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   done;
  logic [7:0]         tx_data;
  logic               tx_send;
  logic               tx_done;
  logic               busy;
  logic [OW-1:0]      owner;
  logic               timeout_err;

  // Client logic and transmitter side
  modport master (
    output req, req_data, tx_done,
    input  ack, done, tx_data, tx_send, busy, owner, timeout_err
  );

  // Arbiter side
  modport slave (
    input  req, req_data, tx_done,
    output ack, done, tx_data, tx_send, busy, owner, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - Shares one UART transmitter among N_REQ requesters; UART_ARB_FIXED_PRIO_EN selects fixed priority
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int SEND_HOLD      = 5,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t             state_q, state_d;
  state_t             post_xfer_state;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               tx_send_q, tx_send_d;
  logic               timeout_q, timeout_d;
  logic [31:0]        hold_q, hold_d;
  logic [31:0]        wd_q, wd_d;
  logic [31:0]        gap_q, gap_d;
  logic               tx_done_q;
  logic               tx_done_rise;
  logic               wd_expired;
  int                 win_idx;

  assign tx_done_rise    = bus.tx_done & ~tx_done_q;
  assign wd_expired      = (TIMEOUT_CYCLES != 0) && (wd_q == 32'(TIMEOUT_CYCLES));
  // A zero-length gap means a finished transfer returns straight to IDLE
  assign post_xfer_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  // Winner selection; the reverse scan leaves the first hit in search order
  always_comb begin
    win_idx = 0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win_idx = i;
    end
`else
    for (int i = N_REQ; i >= 1; i--) begin
      if (bus.req[(int'(owner_q) + i) % N_REQ]) win_idx = (int'(owner_q) + i) % N_REQ;
    end
`endif
  end

  // Next-state and next-output logic; ack/done/timeout are single-cycle pulses
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    owner_d   = owner_q;
    tx_send_d = tx_send_q;
    ack_d     = '0;
    done_d    = '0;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    wd_d      = wd_q;
    gap_d     = gap_q;

    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          state_d          = S_LAUNCH;
          tx_data_d        = bus.req_data[8*win_idx +: 8];
          owner_d          = OW'(win_idx);
          ack_d[win_idx]   = 1'b1;
          tx_send_d        = 1'b1;
          hold_d           = 32'd1;
          wd_d             = 32'd1;
        end
      end

      S_LAUNCH: begin
        wd_d = wd_q + 32'd1;
        if (wd_expired) begin
          timeout_d = 1'b1;
          tx_send_d = 1'b0;
          state_d   = post_xfer_state;
          gap_d     = 32'd1;
          hold_d    = '0;
          wd_d      = '0;
        end else if (hold_q == 32'(SEND_HOLD)) begin
          tx_send_d = 1'b0;
          state_d   = S_WAIT;
          hold_d    = '0;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end

      S_WAIT: begin
        wd_d = wd_q + 32'd1;
        // Completion takes precedence over a watchdog expiry on the same edge
        if (tx_done_rise) begin
          done_d[owner_q] = 1'b1;
          state_d         = post_xfer_state;
          gap_d           = 32'd1;
          wd_d            = '0;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          tx_send_d = 1'b0;
          state_d   = post_xfer_state;
          gap_d     = 32'd1;
          wd_d      = '0;
        end
      end

      S_GAP: begin
        if (gap_q >= 32'(GAP_CYCLES)) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and registered-output update with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
      owner_q   <= OW'(N_REQ - 1);
      ack_q     <= '0;
      done_q    <= '0;
      tx_send_q <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      wd_q      <= '0;
      gap_q     <= '0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      owner_q   <= owner_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      tx_send_q <= tx_send_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      tx_done_q <= bus.tx_done;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.owner       = owner_q;
  assign bus.ack         = ack_q;
  assign bus.done        = done_q;
  assign bus.tx_send     = tx_send_q;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - Directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(
    .N_REQ(4),
    .SEND_HOLD(5),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

`ifdef UART_ARB_FIXED_PRIO_EN
  localparam int RR_GRANTS = 4;
`else
  localparam int RR_GRANTS = 5;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int send_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (|bus.done)      done_cnt <= done_cnt + 1;
    if (bus.timeout_err) to_cnt  <= to_cnt + 1;
    if (bus.tx_send)    send_cnt <= send_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    oh_idx = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) oh_idx = i;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.tx_done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Wait for the next ack; optionally raise tx_done dly clocks later and check done
  task automatic serve(output int idx, output int at, output logic [7:0] data,
                       input int dly, input bit raise);
    int n;
    n = 0;
    idx = -1;
    at = -1;
    data = 8'h00;
    while (bus.ack == 4'b0 && n < 300) begin
      tick();
      n++;
    end
    check("ack_seen", {31'b0, bus.ack != 4'b0}, 32'd1);
    if (bus.ack != 4'b0) begin
      check("ack_onehot", $countones(bus.ack), 32'd1);
      idx = oh_idx(bus.ack);
      at = cyc;
      data = bus.tx_data;
      if (raise) begin
        repeat (dly) tick();
        bus.tx_done = 1'b1;
        tick();
        check("done_idx", {28'b0, bus.done}, {28'b0, 4'b1 << idx});
        bus.tx_done = 1'b0;
      end
    end
  endtask

  initial begin
    int idx, at, at2, prev_at, t_to, d0, s0, n, t0;
    logic [7:0] data;
    int exp_rr[5] = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.tx_done = 1'b0;
    repeat (2) tick();

    // Reset values
    check("rst_tx_send", bus.tx_send, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_owner", bus.owner, 3);
    check("rst_timeout", bus.timeout_err, 0);
    rst = 1'b0;
    tick();

    // Single request from requester 2
    s0 = send_cnt;
    bus.req = 4'b0100;
    bus.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    tick();
    check("s1_ack", bus.ack, 4'b0100);
    check("s1_send", bus.tx_send, 1);
    check("s1_busy", bus.busy, 1);
    check("s1_data", bus.tx_data, 8'hA5);
    check("s1_owner", bus.owner, 2);
    bus.req = '0;
    tick();
    check("s1_ack_pulse", bus.ack, 0);
    repeat (39) tick();
    bus.tx_done = 1'b1;
    tick();
    check("s1_done", bus.done, 4'b0100);
    check("s1_data_stable", bus.tx_data, 8'hA5);
    check("s1_send_len", send_cnt - s0, 5);
    bus.tx_done = 1'b0;
    tick();
    check("s1_done_pulse", bus.done, 0);
    check("s1_busy_gap", bus.busy, 1);
    tick();
    check("s1_busy_idle", bus.busy, 0);

    // Round-robin with all requesters asserted, fastest completion
    do_reset();
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req = 4'b1111;
    prev_at = 0;
    for (int g = 0; g < RR_GRANTS; g++) begin
      serve(idx, at, data, 5, 1'b1);
      check("rr_order", idx, exp_rr[g]);
      check("rr_data", data, 8'h10 + exp_rr[g]);
      if (g > 0) check("rr_spacing", at - prev_at, 9);
      prev_at = at;
`ifdef UART_ARB_FIXED_PRIO_EN
      if (idx >= 0) bus.req[idx] = 1'b0;
`endif
    end
    bus.req = '0;

    // Watchdog expiry with a second requester pending
    do_reset();
    d0 = done_cnt;
    t0 = to_cnt;
    bus.req_data = {8'h00, 8'h00, 8'hB1, 8'hB0};
    bus.req = 4'b0011;
    serve(idx, at, data, 0, 1'b0);
    check("to_first", idx, 0);
    bus.req[0] = 1'b0;
    n = 0;
    while (!bus.timeout_err && n < 300) begin
      tick();
      n++;
    end
    check("to_seen", bus.timeout_err, 1);
    check("to_latency", cyc - at, 100);
    check("to_send_low", bus.tx_send, 0);
    t_to = cyc;
    tick();
    check("to_pulse", bus.timeout_err, 0);
    check("to_no_done", done_cnt - d0, 0);
    serve(idx, at2, data, 5, 1'b1);
    check("to_next_idx", idx, 1);
    check("to_next_lat", at2 - t_to, 3);
    check("to_count", to_cnt - t0, 1);

    // tx_done already high before launch is not a completion
    do_reset();
    d0 = done_cnt;
    bus.tx_done = 1'b1;
    tick();
    bus.req_data = {8'hD3, 24'h000000};
    bus.req = 4'b1000;
    serve(idx, at, data, 0, 1'b0);
    check("stale_idx", idx, 3);
    check("stale_data", data, 8'hD3);
    bus.req = '0;
    repeat (20) tick();
    check("stale_no_done", done_cnt - d0, 0);
    bus.tx_done = 1'b0;
    tick();
    bus.tx_done = 1'b1;
    tick();
    check("stale_done", bus.done, 4'b1000);
    bus.tx_done = 1'b0;

    // Reset asserted ten clocks into WAIT
    do_reset();
    d0 = done_cnt;
    bus.req_data = {8'h00, 8'h00, 8'hC1, 8'hC0};
    bus.req = 4'b0010;
    serve(idx, at, data, 0, 1'b0);
    check("mr_first", idx, 1);
    bus.req = '0;
    repeat (15) tick();
    check("mr_busy_before", bus.busy, 1);
    bus.req = 4'b0011;
    #2 rst = 1'b1;
    #1;
    check("mr_tx_send", bus.tx_send, 0);
    check("mr_tx_data", bus.tx_data, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_owner", bus.owner, 3);
    check("mr_ack", bus.ack, 0);
    check("mr_done", bus.done, 0);
    check("mr_timeout", bus.timeout_err, 0);
    repeat (2) tick();
    rst = 1'b0;
    check("mr_no_done", done_cnt - d0, 0);
    serve(idx, at, data, 5, 1'b1);
    check("mr_after_idx", idx, 0);
    check("mr_after_data", data, 8'hC0);

    // Watchdog expiry and completion on the same edge
    do_reset();
    t0 = to_cnt;
    bus.req_data = {8'h00, 8'hE2, 8'h00, 8'h00};
    bus.req = 4'b0100;
    serve(idx, at, data, 0, 1'b0);
    check("col_idx", idx, 2);
    bus.req = '0;
    repeat (99) tick();
    bus.tx_done = 1'b1;
    tick();
    check("col_done", bus.done, 4'b0100);
    check("col_no_timeout", bus.timeout_err, 0);
    bus.tx_done = 1'b0;
    repeat (5) tick();
    check("col_to_count", to_cnt - t0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end
endmodule
